// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the two-port cache refill read arbiter.
package axi_read_arbiter_pkg;

    localparam int BURST_LEN  = 8;   // 64-bit beats per line refill
    localparam int LINE_BYTES = 64;  // cache line size in bytes

    localparam logic [7:0]  AXI_ARLEN      = 8'(BURST_LEN - 1);
    localparam logic [2:0]  AXI_ARSIZE     = 3'd3;   // 8 bytes per beat
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  LAST_BEAT      = 3'(BURST_LEN - 1);
    localparam logic [63:0] LINE_MASK      = 64'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Owner encoding doubles as the one-hot grant vector {dc, ic}.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_IC   = 2'b01,
        OWNER_DC   = 2'b10
    } owner_t;

    // Clear the byte offset within a cache line.
    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return addr & ~LINE_MASK;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Bundle of the requester-side and AXI read-channel signals around the arbiter.
// The arbiter uses the master modport (it masters the AXI read bus and serves
// both caches); the surrounding caches and memory use the slave modport.
interface axi_read_arbiter_if;

    logic        ic_req_valid;
    logic [63:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_rvalid;
    logic        ic_rready;

    logic        dc_req_valid;
    logic [63:0] dc_req_addr;
    logic        dc_req_ready;
    logic        dc_rvalid;
    logic        dc_rready;

    logic [63:0] rdata;
    logic        rlast;

    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid;
    logic        m_axi_rlast;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rready;

    modport master (
        input  ic_req_valid, ic_req_addr, ic_rready,
        input  dc_req_valid, dc_req_addr, dc_rready,
        output ic_req_ready, ic_rvalid, dc_req_ready, dc_rvalid,
        output rdata, rlast,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rlast, m_axi_rdata,
        output m_axi_rready
    );

    modport slave (
        output ic_req_valid, ic_req_addr, ic_rready,
        output dc_req_valid, dc_req_addr, dc_rready,
        input  ic_req_ready, ic_rvalid, dc_req_ready, dc_rvalid,
        input  rdata, rlast,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rlast, m_axi_rdata,
        input  m_axi_rready
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 is the I-cache, bit 1 the D-cache.
// The D-cache is favoured after reset; whichever port is granted loses the
// next tie.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,   // grant is being consumed this cycle
    output logic [1:0] grant
);

    logic prio_dc;

    // Pick the favoured port on a tie, otherwise whichever port is requesting.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        grant = 2'b00;
        if (req[1] && (prio_dc || !req[0])) begin
            grant = 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end
    end

    // Hand priority to the port that was not just granted.
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            prio_dc <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            prio_dc <= grant[0];
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between the I-cache and D-cache refill paths.
// One line burst is outstanding at a time; the owner keeps the channel from
// grant until the beat carrying m_axi_rlast is accepted.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    axi_read_arbiter_if.master bus,
    output logic [1:0]         owner,
    output logic               protocol_err
);

    state_t      state_q, state_d;
    owner_t      owner_q;
    logic [63:0] araddr_q;
    logic [2:0]  beat_q;
    logic        err_q;
    logic [1:0]  grant;
    logic        idle_grant;
    logic        rready;
    logic        beat_fire;
    logic        burst_done;

    rr_arbiter2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     ({bus.dc_req_valid, bus.ic_req_valid}),
        .advance (idle_grant),
        .grant   (grant)
    );

    // A grant is only offered while idle and not being reset, so a requester
    // never sees req_ready for a request the state machine then ignores.
    assign idle_grant = (state_q == ST_IDLE) && !reset && (grant != 2'b00);
    assign bus.ic_req_ready = idle_grant && grant[0];
    assign bus.dc_req_ready = idle_grant && grant[1];

    // The AXI ready is the owning cache's ready; nobody else can stall the bus.
    assign rready = (state_q != ST_DATA)  ? 1'b0 :
                    (owner_q == OWNER_IC) ? bus.ic_rready :
                    (owner_q == OWNER_DC) ? bus.dc_rready : 1'b0;
    assign beat_fire  = bus.m_axi_rvalid && rready;
    assign burst_done = beat_fire && bus.m_axi_rlast;

    assign bus.m_axi_rready  = rready;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = AXI_ARLEN;
    assign bus.m_axi_arsize  = AXI_ARSIZE;
    assign bus.m_axi_arburst = AXI_BURST_INCR;
    assign bus.rdata         = bus.m_axi_rdata;
    assign bus.rlast         = bus.m_axi_rlast;
    assign owner             = owner_q;
    assign protocol_err      = err_q;

    // Next-state logic plus address-valid and per-port beat-valid steering.
    always_comb begin
        state_d           = state_q;
        bus.m_axi_arvalid = 1'b0;
        bus.ic_rvalid     = 1'b0;
        bus.dc_rvalid     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (idle_grant) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                bus.m_axi_arvalid = 1'b1;
                if (bus.m_axi_arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                bus.ic_rvalid = (owner_q == OWNER_IC) && bus.m_axi_rvalid;
                bus.dc_rvalid = (owner_q == OWNER_DC) && bus.m_axi_rvalid;
                if (burst_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Capture owner and line address at grant; release ownership on the last beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q  <= OWNER_NONE;
            araddr_q <= '0;
        end else if (idle_grant) begin
            owner_q  <= owner_t'(grant);
            araddr_q <= line_align(grant[1] ? bus.dc_req_addr : bus.ic_req_addr);
        end else if (burst_done) begin
            owner_q  <= OWNER_NONE;
        end
    end

    // Count accepted beats; cleared while the address phase is in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_q <= '0;
        end else if (state_q == ST_ADDR) begin
            beat_q <= '0;
        end else if (beat_fire) begin
            beat_q <= beat_q + 3'd1;
        end
    end

    // Sticky flag when rlast does not coincide with the final beat position.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (beat_fire && (bus.m_axi_rlast != (beat_q == LAST_BEAT))) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with a transaction-level reference model
// compared against the outputs every cycle.
module tb_axi_read_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] owner;
    logic       protocol_err;

    axi_read_arbiter_if bus();

    axi_read_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .owner        (owner),
        .protocol_err (protocol_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] rx_q[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 address, 2 data; owner 0 none, 1 ic, 2 dc.
    int          m_phase;
    int          m_owner;
    int          m_beats;
    logic [63:0] m_addr;
    bit          m_err;
    bit          m_fav_dc;

    initial begin : model_compare
        int          w;
        bit          exp_rready;
        logic [63:0] a;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_phase  = 0;
                m_owner  = 0;
                m_beats  = 0;
                m_addr   = 64'd0;
                m_err    = 1'b0;
                m_fav_dc = 1'b1;
            end else begin
                w = 0;
                if (m_phase == 0) begin
                    if (bus.ic_req_valid && bus.dc_req_valid) w = m_fav_dc ? 2 : 1;
                    else if (bus.dc_req_valid)                w = 2;
                    else if (bus.ic_req_valid)                w = 1;
                end
                exp_rready = (m_phase == 2) &&
                             ((m_owner == 1 && bus.ic_rready) || (m_owner == 2 && bus.dc_rready));

                check("m_ic_req_ready", 64'(bus.ic_req_ready), 64'(w == 1));
                check("m_dc_req_ready", 64'(bus.dc_req_ready), 64'(w == 2));
                check("m_owner",        64'(owner),            64'(m_owner));
                check("m_arvalid",      64'(bus.m_axi_arvalid), 64'(m_phase == 1));
                check("m_araddr",       bus.m_axi_araddr,      m_addr);
                check("m_arlen",        64'(bus.m_axi_arlen),  64'd7);
                check("m_arsize",       64'(bus.m_axi_arsize), 64'd3);
                check("m_arburst",      64'(bus.m_axi_arburst), 64'd1);
                check("m_rready",       64'(bus.m_axi_rready), 64'(exp_rready));
                check("m_ic_rvalid",    64'(bus.ic_rvalid),
                      64'(m_phase == 2 && m_owner == 1 && bus.m_axi_rvalid));
                check("m_dc_rvalid",    64'(bus.dc_rvalid),
                      64'(m_phase == 2 && m_owner == 2 && bus.m_axi_rvalid));
                check("m_rdata",        bus.rdata,             bus.m_axi_rdata);
                check("m_rlast",        64'(bus.rlast),        64'(bus.m_axi_rlast));
                check("m_protocol_err", 64'(protocol_err),     64'(m_err));

                if ((bus.ic_rvalid && bus.ic_rready) || (bus.dc_rvalid && bus.dc_rready))
                    rx_q.push_back(bus.rdata);

                case (m_phase)
                    0: if (w != 0) begin
                        a        = (w == 2) ? bus.dc_req_addr : bus.ic_req_addr;
                        m_addr   = a - (a % 64);
                        m_owner  = w;
                        m_fav_dc = (w == 1);
                        m_phase  = 1;
                    end
                    1: if (bus.m_axi_arready) begin
                        m_phase = 2;
                        m_beats = 0;
                    end
                    2: if (bus.m_axi_rvalid && exp_rready) begin
                        if (bus.m_axi_rlast != ((m_beats % 8) == 7)) m_err = 1'b1;
                        m_beats++;
                        if (bus.m_axi_rlast) begin
                            m_phase = 0;
                            m_owner = 0;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rready(input int port, input logic v);
        if (port == 1) bus.ic_rready = v;
        else           bus.dc_rready = v;
    endtask

    task automatic reset_dut();
        bus.ic_req_valid  = 1'b0;
        bus.dc_req_valid  = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic do_request(input int port, input logic [63:0] addr, input string name);
        bit seen;
        seen = 1'b0;
        if (port == 1) begin
            bus.ic_req_valid = 1'b1;
            bus.ic_req_addr  = addr;
        end else begin
            bus.dc_req_valid = 1'b1;
            bus.dc_req_addr  = addr;
        end
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = (port == 1) ? bus.ic_req_ready : bus.dc_req_ready;
        end
        check(name, 64'(seen), 64'd1);
        tick();
        if (port == 1) bus.ic_req_valid = 1'b0;
        else           bus.dc_req_valid = 1'b0;
    endtask

    task automatic addr_phase(input int delay);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = bus.m_axi_arvalid;
        end
        check("arvalid_wait", 64'(seen), 64'd1);
        tick();
        repeat (delay) tick();
        bus.m_axi_arready = 1'b1;
        tick();
        bus.m_axi_arready = 1'b0;
    endtask

    // Present nbeats beats; rlast on beat last_at (-1: never). The owner drops
    // its rready for stall_len cycles before beat stall_at.
    task automatic data_phase(input int port, input int nbeats, input int last_at,
                              input logic [63:0] base, input int stall_at, input int stall_len);
        bit took;
        for (int i = 0; i < nbeats; i++) begin
            took = 1'b0;
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = base + 64'(i);
            bus.m_axi_rlast  = (i == last_at);
            if (i == stall_at) begin
                set_rready(port, 1'b0);
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clock);
                    check("rready_stalled", 64'(bus.m_axi_rready), 64'd0);
                    tick();
                end
                set_rready(port, 1'b1);
            end
            for (int k = 0; k < 100 && !took; k++) begin
                @(negedge clock);
                took = bus.m_axi_rready;
            end
            check("beat_wait", 64'(took), 64'd1);
            tick();
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected end of stimulus");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        reset             = 1'b1;
        bus.ic_req_valid  = 1'b0;
        bus.ic_req_addr   = 64'd0;
        bus.dc_req_valid  = 1'b0;
        bus.dc_req_addr   = 64'd0;
        bus.ic_rready     = 1'b1;
        bus.dc_rready     = 1'b1;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rdata   = 64'd0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset values.
        @(negedge clock);
        check("rst_owner",   64'(owner),             64'd0);
        check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        check("rst_rready",  64'(bus.m_axi_rready),  64'd0);
        check("rst_araddr",  bus.m_axi_araddr,       64'd0);
        check("rst_err",     64'(protocol_err),      64'd0);
        check("rst_ic_rdy",  64'(bus.ic_req_ready),  64'd0);
        tick();

        // Lone I-cache refill of 0x1234.
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 64'h1234;
        @(negedge clock);
        check("ic_ready_pulse", 64'(bus.ic_req_ready), 64'd1);
        check("dc_ready_quiet", 64'(bus.dc_req_ready), 64'd0);
        tick();
        bus.ic_req_valid = 1'b0;
        @(negedge clock);
        check("araddr_aligned",  bus.m_axi_araddr,       64'h1200);
        check("arlen_7",         64'(bus.m_axi_arlen),   64'd7);
        check("owner_ic",        64'(owner),             64'd1);
        check("ic_ready_single", 64'(bus.ic_req_ready),  64'd0);
        addr_phase(2);
        rx_q.delete();
        data_phase(1, 8, 7, 64'hA000, -1, 0);
        @(negedge clock);
        check("owner_released", 64'(owner),      64'd0);
        check("ic_beats",       64'(rx_q.size()), 64'd8);
        check("ic_first_beat",  rx_q[0],          64'hA000);
        check("ic_last_beat",   rx_q[7],          64'hA007);
        tick();

        // Simultaneous requests after reset: D-cache first.
        reset_dut();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 64'h2000_0010;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_addr  = 64'h3000_00FF;
        @(negedge clock);
        check("tie_dc_first", 64'(bus.dc_req_ready), 64'd1);
        check("tie_ic_waits", 64'(bus.ic_req_ready), 64'd0);
        tick();
        bus.dc_req_valid = 1'b0;
        @(negedge clock);
        check("araddr_dc", bus.m_axi_araddr, 64'h3000_00C0);
        check("owner_dc",  64'(owner),       64'd2);
        addr_phase(0);
        data_phase(2, 8, 7, 64'hD000, -1, 0);
        @(negedge clock);
        check("ic_granted_after_dc", 64'(bus.ic_req_ready), 64'd1);
        tick();
        bus.ic_req_valid = 1'b0;
        @(negedge clock);
        check("araddr_ic", bus.m_axi_araddr, 64'h2000_0000);
        addr_phase(0);

        // Owner back-pressure for 3 cycles before beat 3.
        rx_q.delete();
        data_phase(1, 8, 7, 64'h1000, 3, 3);
        @(negedge clock);
        check("stall_beats", 64'(rx_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) check("stall_order", rx_q[i], 64'h1000 + 64'(i));
        check("stall_no_err", 64'(protocol_err), 64'd0);
        tick();

        // Round robin: D-cache was last granted, so the I-cache wins this tie.
        do_request(2, 64'h3000_0100, "dc_alone");
        addr_phase(0);
        data_phase(2, 8, 7, 64'hE000, -1, 0);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 64'h2000_0400;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_addr  = 64'h3000_0200;
        @(negedge clock);
        check("tie_ic_after_dc", 64'(bus.ic_req_ready), 64'd1);
        check("tie_dc_loses",    64'(bus.dc_req_ready), 64'd0);
        tick();
        bus.ic_req_valid = 1'b0;
        addr_phase(1);
        data_phase(1, 8, 7, 64'hB000, -1, 0);
        @(negedge clock);
        check("dc_after_ic", 64'(bus.dc_req_ready), 64'd1);
        tick();
        bus.dc_req_valid = 1'b0;
        addr_phase(0);
        data_phase(2, 8, 7, 64'hC000, -1, 0);

        // Early rlast on beat 5.
        do_request(1, 64'h5000_0008, "ic_short");
        addr_phase(0);
        data_phase(1, 6, 5, 64'h5000, -1, 0);
        @(negedge clock);
        check("err_early_rlast",  64'(protocol_err), 64'd1);
        check("owner_after_early", 64'(owner),       64'd0);
        tick();
        do_request(2, 64'h3000_0300, "dc_after_err");
        addr_phase(0);
        data_phase(2, 8, 7, 64'h6000, -1, 0);
        @(negedge clock);
        check("err_sticky", 64'(protocol_err), 64'd1);
        tick();

        // Reset while beat 3 is on the bus.
        do_request(1, 64'h8000_0077, "ic_reset_victim");
        addr_phase(0);
        data_phase(1, 3, -1, 64'h7000, -1, 0);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 64'h7003;
        bus.m_axi_rlast  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        @(negedge clock);
        check("abort_owner",   64'(owner),             64'd0);
        check("abort_err",     64'(protocol_err),      64'd0);
        check("abort_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        check("abort_rready",  64'(bus.m_axi_rready),  64'd0);
        check("abort_ic_rv",   64'(bus.ic_rvalid),     64'd0);
        check("abort_araddr",  bus.m_axi_araddr,       64'd0);
        tick();

        // Beat 7 without rlast; burst only ends on the rlast of beat 8.
        do_request(1, 64'h6000_003F, "ic_long");
        addr_phase(0);
        data_phase(1, 9, 8, 64'h9000, -1, 0);
        @(negedge clock);
        check("err_missing_rlast", 64'(protocol_err), 64'd1);
        check("owner_after_long",  64'(owner),        64'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 BURST_LEN, 8, beats per line refill (64-bit beats).
REQ-002 LINE_BYTES, 64, cache line size; request address aligned down to this.
REQ-003 clock  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ic_req_valid  in  1  I-cache refill request.
REQ-006 ic_req_addr  in  64  I-cache miss address.
REQ-007 ic_req_ready  out  1  I-cache request accepted (one-cycle pulse).
REQ-008 ic_rvalid  out  1  data beat valid for I-cache.
REQ-009 ic_rready  in  1  I-cache accepts beat.
REQ-010 dc_req_valid  in  1  D-cache refill request.
REQ-011 dc_req_addr  in  64  D-cache miss address.
REQ-012 dc_req_ready  out  1  D-cache request accepted (one-cycle pulse).
REQ-013 dc_rvalid  out  1  data beat valid for D-cache.
REQ-014 dc_rready  in  1  D-cache accepts beat.
REQ-015 rdata  out  64  beat data, broadcast to both requesters.
REQ-016 rlast  out  1  final beat of burst, broadcast.
REQ-017 m_axi_arvalid  out  1  AXI read address valid.
REQ-018 m_axi_arready  in  1  AXI read address ready.
REQ-019 m_axi_araddr  out  64  line-aligned burst address.
REQ-020 m_axi_arlen  out  8  constant BURST_LEN-1 (7).
REQ-021 m_axi_arsize  out  3  constant 3 (8 bytes).
REQ-022 m_axi_arburst  out  2  constant 1 (INCR).
REQ-023 m_axi_rvalid / m_axi_rlast  in  1 each  AXI read beat valid / last.
REQ-024 m_axi_rdata  in  64  AXI read data.
REQ-025 m_axi_rready  out  1  AXI read ready.
REQ-026 owner  out  2  00 none, 01 I-cache, 10 D-cache.
REQ-027 protocol_err  out  1  sticky: rlast/beat-count mismatch.

Function
REQ-028 FSM states IDLE, ADDR, DATA; one burst outstanding at a time.
REQ-029 IDLE: any req_valid -> grant, latch addr with low log2(LINE_BYTES) bits zeroed, pulse that port's req_ready, go ADDR next cycle.
REQ-030 Simultaneous requests: round-robin; D-cache wins first after reset; last-granted port loses the next tie.
REQ-031 ADDR: arvalid=1, araddr stable until arvalid&&arready; then DATA, beat counter=0; ADDR->DATA latency one cycle after handshake.
REQ-032 DATA: m_axi_rready = owner's rready; owner's rvalid = m_axi_rvalid; other port rvalid=0; rdata/rlast combinational pass-through.
REQ-033 Beat counted on m_axi_rvalid&&m_axi_rready; counter 3 bits, wraps at BURST_LEN.
REQ-034 Burst ends on accepted beat with m_axi_rlast=1 -> IDLE, owner=00; new grant possible the following cycle.
REQ-035 rlast on beat != 7, or beat 7 without rlast: set protocol_err; FSM still terminates only on rlast.
REQ-036 Requests arriving during ADDR/DATA wait; req_valid must hold until req_ready; no preemption.
REQ-037 m_axi_rready=0 outside DATA; arvalid=0 outside ADDR.

Reset
REQ-038 Reset: state IDLE, owner=00, arvalid=0, rready=0, all req_ready/rvalid=0, araddr=0, counter=0, protocol_err=0, RR pointer favours D-cache.
REQ-039 Reset mid-burst aborts immediately; remaining AXI beats are the bench's responsibility to drain.

Structure
REQ-040 Shared package: state enum, owner encoding, AXI burst/size constants, LINE_BYTES/BURST_LEN defaults.
REQ-041 One sub-module rr_arbiter2 (2-way round-robin grant with pointer update).

Verification
REQ-042 ic request addr 0x1234 alone -> ic_req_ready pulse, araddr=0x1200, arlen=7, 8 beats to ic only, owner back to 00.
REQ-043 ic+dc same cycle after reset -> dc granted first, ic granted next after dc's rlast.
REQ-044 rready from owner held low 3 cycles mid-burst -> m_axi_rready low, counter frozen, all 8 beats delivered in order.
REQ-045 rlast asserted on beat 5 -> protocol_err=1, FSM returns IDLE, error stays set until reset.
REQ-046 reset asserted during DATA beat 3 -> next cycle all outputs at reset values, owner=00.
